// File: rtl/rom_fetch_if.sv
// rom_fetch_if: ROM address/data pair plus the fetch-to-consumer handshake and redirect request.
interface rom_fetch_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_q;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_addr;
    logic                  insn_valid;
    logic                  insn_ready;
    logic [DATA_WIDTH-1:0] insn_data;
    logic [ADDR_WIDTH-1:0] insn_addr;
    modport master (
        output rom_addr, insn_valid, insn_data, insn_addr,
        input  rom_q, redirect_valid, redirect_addr, insn_ready
    );
    modport slave (
        input  rom_addr, insn_valid, insn_data, insn_addr,
        output rom_q, redirect_valid, redirect_addr, insn_ready
    );
endinterface

// File: rtl/rom_fetch.sv
// rom_fetch: sequential ROM fetch with a 2-entry output buffer, credit-based issue and redirect flush.
module rom_fetch #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input logic         clk,
    input logic         resetn,
    rom_fetch_if.master bus
);
    localparam int W = ADDR_WIDTH + DATA_WIDTH;
    logic [ADDR_WIDTH-1:0] pc, inflight_addr;
    logic                  inflight, pop, issue;
    logic [1:0]            count, base, count_n;
    logic [2:0]            occ;
    logic [W-1:0]          e0, e1, e0_n, e1_n, push_word;
    // Entry e0 is always the head; base is the occupancy left after this cycle's pop.
    always_comb begin
        pop       = (count != 2'd0) && bus.insn_ready;
        occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
        issue     = !bus.redirect_valid && (occ < 3'd2);
        base      = count - {1'b0, pop};
        push_word = {inflight_addr, bus.rom_q};
        e0_n      = (inflight && base == 2'd0) ? push_word : (pop ? e1 : e0);
        e1_n      = (inflight && base == 2'd1) ? push_word : e1;
        count_n   = bus.redirect_valid ? 2'd0 : base + {1'b0, inflight};
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc            <= RESET_ADDR;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            count         <= 2'd0;
            e0            <= '0;
            e1            <= '0;
        end else begin
            pc            <= bus.redirect_valid ? bus.redirect_addr : (issue ? pc + 1'b1 : pc);
            inflight      <= issue;
            inflight_addr <= issue ? pc : inflight_addr;
            count         <= count_n;
            e0            <= e0_n;
            e1            <= e1_n;
        end
    end
    assign bus.rom_addr                    = pc;
    assign bus.insn_valid                  = count != 2'd0;
    assign {bus.insn_addr, bus.insn_data}  = e0;
endmodule
